hilo_muldiv_unit: RTL

- Producer side of the HI/LO path: owns the architectural HI and LO registers and writes them from MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits in EX. Accepts an operation from the ID/EX stage, stalls the pipeline while a divide iterates, then commits its result to HI/LO.
- Outputs the current HI/LO and a one-cycle commit strobe with the committed values, so the EX/MEM forwarding selector can consume them.

---
 rtl/hilo_pkg.sv | 27 ++
 rtl/div_radix2_core.sv | 54 +++++
 rtl/hilo_muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: data width,
// opcodes, FSM state encoding and a magnitude helper.
package hilo_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per step, done flags
// the cycle in which the final step is taken.
module div_radix2_core #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [WIDTH-1:0] quot_q, rem_q, dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted, trial;

    // rem_q < divisor always holds, so bit WIDTH of the trial is a clean borrow.
    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            dvsr_q <= divisor_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + CW'(1);
            if (!trial[WIDTH]) begin
                rem_q  <= trial[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= shifted[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign done_o = (cnt_q == CW'(DIV_CYCLES - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO producer: MT*, single-cycle multiply and iterative divide,
// with a one-cycle commit strobe for the forwarding network.
module hilo_muldiv_unit
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             commit,
    output logic [WIDTH-1:0] commit_hi,
    output logic [WIDTH-1:0] commit_lo
);
    state_e           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
    logic             mul_sgn_q, q_neg_q, r_neg_q, dz_q, commit_q;

    logic             op_is_div, div_sgn, div_load, div_step, div_done;
    logic [WIDTH-1:0] div_quot, div_rem, quot_s, rem_s;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;

    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign div_sgn   = (op == OP_DIV);
    assign div_load  = (state_q == ST_IDLE) && start && !flush && op_is_div;
    assign div_step  = (state_q == ST_DIV) && !flush;

    div_radix2_core #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (abs_val(rs_val, div_sgn)),
        .divisor_i  (abs_val(rt_val, div_sgn)),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .done_o     (div_done)
    );

    // Sign/zero extension to 2W bits makes one multiplier serve MULT and MULTU.
    assign ext_a  = {{WIDTH{mul_sgn_q & a_q[WIDTH-1]}}, a_q};
    assign ext_b  = {{WIDTH{mul_sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod   = ext_a * ext_b;

    assign quot_s = q_neg_q ? -div_quot : div_quot;
    assign rem_s  = r_neg_q ? -div_rem  : div_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_sgn_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MTHI: begin
                                    hi_q     <= rs_val;
                                    commit_q <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo_q     <= rs_val;
                                    commit_q <= 1'b1;
                                end
                                OP_MULT, OP_MULTU: begin
                                    a_q       <= rs_val;
                                    b_q       <= rt_val;
                                    mul_sgn_q <= (op == OP_MULT);
                                    state_q   <= ST_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    a_q     <= rs_val;
                                    dz_q    <= (rt_val == '0);
                                    q_neg_q <= div_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                    r_neg_q <= div_sgn & rs_val[WIDTH-1];
                                    state_q <= ST_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        hi_q     <= prod[2*WIDTH-1:WIDTH];
                        lo_q     <= prod[WIDTH-1:0];
                        commit_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                    ST_DIV: begin
                        if (div_done) state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        // Divide-by-zero keeps the architected result: all-ones quotient, dividend as remainder.
                        hi_q     <= dz_q ? a_q : rem_s;
                        lo_q     <= dz_q ? '1  : quot_s;
                        commit_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign commit    = commit_q;
    assign commit_hi = hi_q;
    assign commit_lo = lo_q;

endmodule
